pkt_dst_receiver: RTL

- Destination-side endpoint of the router's output interface (dst_valid/dst_ready, dst_addr, pack_t, payload, eop, ack).
- Accepts beats addressed to its own port and stores them in a frame buffer.
- Exposes only fully committed frames on a read stream and pulses ack once per committed frame.
- Drops mis-addressed frames; discards malformed or oversize frames by rolling back the write pointer.

---
 rtl/pkt_dst_receiver.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pkt_dst_receiver.sv
// Destination endpoint of the router: buffers frames addressed to MY_ADDR and exposes only
// fully committed frames on the rx stream; malformed or oversize frames are rolled back.
module pkt_dst_receiver #(
    parameter logic [1:0] MY_ADDR = 2'b00,
    parameter int         DEPTH   = 16,
    parameter int         MAX_LEN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dst_valid,
    output logic       dst_ready,
    input  logic [1:0] dst_addr,
    input  logic [1:0] pack_t,
    input  logic [7:0] payload,
    input  logic       eop,
    output logic       ack,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_ctrl,
    output logic       rx_last,
    output logic [7:0] frame_cnt,
    output logic [7:0] err_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_LEN + 1);

    localparam logic [1:0] T_CTRL = 2'b01;
    localparam logic [1:0] T_NULL = 2'b10;
    localparam logic [1:0] T_ILL  = 2'b11;

    typedef enum logic [1:0] {IDLE, RECV, DROP, ACK} state_t;

    state_t        state;
    logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
    logic [CW-1:0] beat_cnt;
    logic [9:0]    mem [DEPTH];
    logic          full, beat, store, rd_fire;

    assign full     = (wr_ptr - rd_ptr) == PW'(DEPTH);
    assign rx_valid = commit_ptr != rd_ptr;
    assign rd_fire  = rx_valid && rx_ready;
    assign {rx_ctrl, rx_last, rx_data} = mem[rd_ptr[AW-1:0]];

    // NOTE: dst_ready gets a default before the case so no path can infer a latch.
    always_comb begin
        dst_ready = 1'b0;
        if (reset) begin
            case (state)
                IDLE, RECV: dst_ready = !full;
                DROP:       dst_ready = 1'b1;
                default:    dst_ready = 1'b0;
            endcase
        end
    end

    assign beat  = dst_valid && dst_ready;
    assign store = beat && !pack_t[1] &&
                   (state == RECV || (state == IDLE && dst_addr == MY_ADDR));

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // NOTE: the buffer is not reset; the pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr[AW-1:0]] <= {pack_t == T_CTRL, eop, payload};
    end

    // NOTE: non-blocking updates, so a later rollback of wr_ptr overrides the write increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            beat_cnt   <= '0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
            ack        <= 1'b0;
        end else begin
            ack <= 1'b0;
            if (store) wr_ptr <= wr_ptr + 1'b1;
            case (state)
                IDLE: if (beat) begin
                    if (dst_addr != MY_ADDR) begin
                        if (!eop) state <= DROP;
                    end else if (pack_t == T_ILL) begin
                        err_cnt <= sat_inc(err_cnt);
                        if (!eop) state <= DROP;
                    end else if (pack_t != T_NULL) begin
                        beat_cnt <= CW'(1);
                        if (eop) begin
                            state <= ACK;
                            ack   <= 1'b1;
                        end else begin
                            state <= RECV;
                        end
                    end
                end
                RECV: if (beat) begin
                    if (pack_t == T_ILL) begin
                        wr_ptr  <= commit_ptr;
                        err_cnt <= sat_inc(err_cnt);
                        state   <= eop ? IDLE : DROP;
                    end else if (eop) begin
                        state <= ACK;
                        ack   <= 1'b1;
                    end else if (store) begin
                        // A frame that reaches MAX_LEN without eop can never be legal.
                        if (beat_cnt == CW'(MAX_LEN - 1)) begin
                            wr_ptr  <= commit_ptr;
                            err_cnt <= sat_inc(err_cnt);
                            state   <= DROP;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                DROP: if (beat && eop) state <= IDLE;
                ACK: begin
                    commit_ptr <= wr_ptr;
                    frame_cnt  <= sat_inc(frame_cnt);
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       rd_ptr <= '0;
        else if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
    end
endmodule
